multiplier_arbiter: RTL and testbench

- Shares one `multiplier` instance between N requesters using round-robin arbitration.
- Per operation: accepts one request, drives the multiplier for one enabled cycle, captures the registered product and applies the fixed-point shift, then returns the result with the requester ID over a valid/ready response port.
- Sits between the PE-local operand sources and the shared multiplier datapath.

---
 rtl/multiplier_arbiter.sv | 138 +++++++++++++
 tb/tb_multiplier_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one registered multiplier between NUM_REQ requesters.
// Each operation: accept, drive multiplier, capture and shift the product, respond.
module multiplier_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH_FAC1 = 8,
  parameter int unsigned DATA_WIDTH_FAC2 = 8,
  parameter int unsigned DATA_WIDTH_PROD = 20,
  parameter int unsigned Q_BITWIDTH      = $clog2(DATA_WIDTH_PROD),
  parameter int unsigned ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH_FAC1-1:0] req_fac1_i,
  input  logic [NUM_REQ*DATA_WIDTH_FAC2-1:0] req_fac2_i,
  input  logic [NUM_REQ*Q_BITWIDTH-1:0]      req_frac_i,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [ID_WIDTH-1:0]                resp_id_o,
  output logic [DATA_WIDTH_PROD-1:0]         resp_product_o,
  output logic                               mul_en_o,
  output logic [DATA_WIDTH_FAC1-1:0]         mul_fac1_o,
  output logic [DATA_WIDTH_FAC2-1:0]         mul_fac2_o,
  output logic [Q_BITWIDTH-1:0]              mul_frac_o,
  input  logic [DATA_WIDTH_PROD-1:0]         mul_product_i
);

  typedef enum logic [1:0] {StIdle, StMul, StCapt, StResp} state_e;

  state_e                       state_q, state_d;
  logic [ID_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]          id_q, id_d;
  logic [DATA_WIDTH_FAC1-1:0]   fac1_q, fac1_d;
  logic [DATA_WIDTH_FAC2-1:0]   fac2_q, fac2_d;
  logic [Q_BITWIDTH-1:0]        frac_q, frac_d;
  logic [DATA_WIDTH_PROD-1:0]   result_q, result_d;
  logic [DATA_WIDTH_PROD-1:0]   shifted;

  logic                         grant_found;
  logic [ID_WIDTH-1:0]          grant_id;

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    if (32'(frac_q) >= DATA_WIDTH_PROD) begin
      shifted = {DATA_WIDTH_PROD{mul_product_i[DATA_WIDTH_PROD-1]}};
    end else begin
      shifted = $signed(mul_product_i) >>> frac_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    fac1_d   = fac1_q;
    fac2_d   = fac2_q;
    frac_d   = frac_q;
    result_d = result_q;

    req_ready_o    = '0;
    resp_valid_o   = 1'b0;
    resp_id_o      = '0;
    resp_product_o = '0;
    mul_en_o       = 1'b0;
    mul_fac1_o     = '0;
    mul_fac2_o     = '0;
    mul_frac_o     = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready_o[grant_id] = 1'b1;
          fac1_d  = req_fac1_i[grant_id*DATA_WIDTH_FAC1 +: DATA_WIDTH_FAC1];
          fac2_d  = req_fac2_i[grant_id*DATA_WIDTH_FAC2 +: DATA_WIDTH_FAC2];
          frac_d  = req_frac_i[grant_id*Q_BITWIDTH +: Q_BITWIDTH];
          id_d    = grant_id;
          state_d = StMul;
        end
      end
      StMul: begin
        mul_en_o   = 1'b1;
        mul_fac1_o = fac1_q;
        mul_fac2_o = fac2_q;
        mul_frac_o = frac_q;
        state_d    = StCapt;
      end
      StCapt: begin
        result_d = shifted;
        state_d  = StResp;
      end
      StResp: begin
        resp_valid_o   = 1'b1;
        resp_id_o      = id_q;
        resp_product_o = result_q;
        if (resp_ready_i) begin
          state_d  = StIdle;
          rr_ptr_d = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      fac1_q   <= '0;
      fac2_q   <= '0;
      frac_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      fac1_q   <= fac1_d;
      fac2_q   <= fac2_d;
      frac_q   <= frac_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench for multiplier_arbiter with a behavioural multiplier and reference model.
module tb_multiplier_arbiter;

  localparam int NR  = 4;
  localparam int W1  = 8;
  localparam int W2  = 8;
  localparam int WP  = 20;
  localparam int QB  = 5;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*W1-1:0]   req_fac1;
  logic [NR*W2-1:0]   req_fac2;
  logic [NR*QB-1:0]   req_frac;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [IDW-1:0]     resp_id;
  logic [WP-1:0]      resp_product;
  logic               mul_en;
  logic signed [W1-1:0] mul_fac1;
  logic signed [W2-1:0] mul_fac2;
  logic [QB-1:0]      mul_frac;
  logic [WP-1:0]      mul_prod = '0;

  logic signed [W1-1:0] fac1_a [NR];
  logic signed [W2-1:0] fac2_a [NR];
  logic [QB-1:0]        frac_a [NR];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rr_m    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared multiplier: registered, one-cycle latency, truncated product.
  always_ff @(posedge clk) begin
    if (mul_en) mul_prod <= WP'(longint'(mul_fac1) * longint'(mul_fac2));
  end

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_fac1[k*W1 +: W1] = fac1_a[k];
      req_fac2[k*W2 +: W2] = fac2_a[k];
      req_frac[k*QB +: QB] = frac_a[k];
    end
  end

  multiplier_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH_FAC1(W1), .DATA_WIDTH_FAC2(W2), .DATA_WIDTH_PROD(WP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fac1_i(req_fac1), .req_fac2_i(req_fac2), .req_frac_i(req_frac),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_product_o(resp_product),
    .mul_en_o(mul_en), .mul_fac1_o(mul_fac1), .mul_fac2_o(mul_fac2),
    .mul_frac_o(mul_frac), .mul_product_i(mul_prod)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint sprod();
    return longint'($signed(resp_product));
  endfunction

  // Reference: wrap product to WP bits, then floor-divide by 2^frac.
  function automatic longint model_prod(input longint a, input longint b, input int frac);
    longint one = 1;
    longint p, d, q;
    p = (a * b) & ((one << WP) - 1);
    if (p >= (one << (WP - 1))) p = p - (one << WP);
    if (frac >= WP) return (p < 0) ? -1 : 0;
    d = one << frac;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_grant(input logic [NR-1:0] m, input int rr);
    for (int i = 0; i < NR; i++) begin
      if (m[(rr + i) % NR]) return (rr + i) % NR;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    rst = 1'b0;
    rr_m = 0;
  endtask

  // One full operation at fixed timing; entered in an IDLE cycle.
  task automatic do_op(input logic [NR-1:0] mask, input int exp_id, input longint exp_prod,
                       input int rdelay, input string tag, output int t_resp);
    req_valid = mask;
    resp_ready = 1'b0;
    #1;
    chk({tag, ".ready"}, longint'(req_ready), longint'(1 << exp_id));
    tick();
    chk({tag, ".mul_en"}, longint'(mul_en), 1);
    chk({tag, ".mul_fac1"}, longint'(mul_fac1), longint'(fac1_a[exp_id]));
    chk({tag, ".mul_fac2"}, longint'(mul_fac2), longint'(fac2_a[exp_id]));
    chk({tag, ".mul_frac"}, longint'(mul_frac), longint'(frac_a[exp_id]));
    chk({tag, ".ready_mul"}, longint'(req_ready), 0);
    tick();
    chk({tag, ".capt_en"}, longint'(mul_en), 0);
    chk({tag, ".capt_fac1"}, longint'(mul_fac1), 0);
    chk({tag, ".capt_valid"}, longint'(resp_valid), 0);
    tick();
    t_resp = cyc;
    chk({tag, ".valid"}, longint'(resp_valid), 1);
    chk({tag, ".id"}, longint'(resp_id), longint'(exp_id));
    chk({tag, ".prod"}, sprod(), exp_prod);
    for (int d = 0; d < rdelay; d++) begin
      tick();
      chk({tag, ".bp_valid"}, longint'(resp_valid), 1);
      chk({tag, ".bp_id"}, longint'(resp_id), longint'(exp_id));
      chk({tag, ".bp_prod"}, sprod(), exp_prod);
      chk({tag, ".bp_ready"}, longint'(req_ready), 0);
      chk({tag, ".bp_en"}, longint'(mul_en), 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    rr_m = (exp_id + 1) % NR;
    chk({tag, ".idle_valid"}, longint'(resp_valid), 0);
    req_valid = '0;
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            fac1;
    int            fac2;
    int            frac;
    int            exp_id;
    longint        exp_prod;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int t, tp, g;
    logic [NR-1:0] m;
    longint e;

    vecs[0] = '{4'b0010,   -3,   7,  0, 1,   -21};
    vecs[1] = '{4'b0001,   96,  80,  4, 0,   480};
    vecs[2] = '{4'b0100,  -96,  80,  4, 2,  -480};
    vecs[3] = '{4'b1000,   -5,   3, 20, 3,    -1};
    vecs[4] = '{4'b0001,    5,   3, 20, 0,     0};
    vecs[5] = '{4'b0010,  127, 127,  0, 1, 16129};
    vecs[6] = '{4'b0100, -128, 127,  7, 2,  -127};
    vecs[7] = '{4'b1000,  100,  -1,  3, 3,   -13};
    vecs[8] = '{4'b0001,  -15,   1, 19, 0,    -1};
    vecs[9] = '{4'b0010, -128,-128, 14, 1,     1};

    for (int k = 0; k < NR; k++) begin
      fac1_a[k] = '0;
      fac2_a[k] = '0;
      frac_a[k] = '0;
    end

    tick();
    do_reset();
    chk("rst.ready", longint'(req_ready), 0);
    chk("rst.valid", longint'(resp_valid), 0);
    chk("rst.id", longint'(resp_id), 0);
    chk("rst.prod", longint'(resp_product), 0);
    chk("rst.mul_en", longint'(mul_en), 0);
    chk("rst.mul_fac1", longint'(mul_fac1), 0);
    chk("rst.mul_fac2", longint'(mul_fac2), 0);
    chk("rst.mul_frac", longint'(mul_frac), 0);

    for (int i = 0; i < 10; i++) begin
      fac1_a[vecs[i].exp_id] = W1'(vecs[i].fac1);
      fac2_a[vecs[i].exp_id] = W2'(vecs[i].fac2);
      frac_a[vecs[i].exp_id] = QB'(vecs[i].frac);
      do_op(vecs[i].mask, vecs[i].exp_id, vecs[i].exp_prod, 0, $sformatf("vec%0d", i), t);
    end

    // Round-robin with all requesters valid: ids 0,1,2,3,0 every 4 cycles.
    do_reset();
    for (int k = 0; k < NR; k++) begin
      fac1_a[k] = W1'(k + 2);
      fac2_a[k] = W2'(-3);
      frac_a[k] = '0;
    end
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(4'b1111, i % NR, longint'(-3 * ((i % NR) + 2)), 0, $sformatf("rr%0d", i), t);
      if (i > 0) chk($sformatf("rr%0d.period", i), longint'(t - tp), 4);
      tp = t;
    end

    // Skip and wrap: rr_ptr at 3 with only 0 and 2 requesting.
    do_op(4'b0100, 2, -12, 0, "skip.setup", t);
    do_op(4'b0101, 0, -6, 0, "skip.a", t);
    do_op(4'b0101, 2, -12, 0, "skip.b", t);
    do_op(4'b0101, 0, -6, 0, "skip.c", t);

    // Long backpressure, then the next grant in the very next cycle.
    do_op(4'b0010, 1, -9, 10, "bp", t);
    do_op(4'b1111, 2, -12, 0, "bp.next", t);

    // Reset while in MUL.
    do_op(4'b0010, 1, -9, 0, "rm.setup", t);
    req_valid = 4'b0100;
    #1;
    chk("rm.ready", longint'(req_ready), 4);
    tick();
    chk("rm.mul_en", longint'(mul_en), 1);
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    rr_m = 0;
    chk("rm.valid", longint'(resp_valid), 0);
    chk("rm.en", longint'(mul_en), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rm.no_resp", longint'(resp_valid), 0);
    end
    do_op(4'b1111, 0, -6, 0, "rm.after", t);

    // Reset while in RESP.
    req_valid = 4'b1000;
    #1;
    chk("rr.ready", longint'(req_ready), 8);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("rr.in_resp", longint'(resp_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_m = 0;
    chk("rr.valid", longint'(resp_valid), 0);
    chk("rr.en", longint'(mul_en), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr.no_resp", longint'(resp_valid), 0);
    end
    do_op(4'b1111, 0, -6, 0, "rr.after", t);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NR; k++) begin
        fac1_a[k] = W1'($urandom_range(0, 255));
        fac2_a[k] = W2'($urandom_range(0, 255));
        frac_a[k] = ($urandom_range(0, 3) == 0) ? QB'($urandom_range(0, 31))
                                               : QB'($urandom_range(0, 8));
      end
      m = NR'($urandom_range(1, 15));
      g = model_grant(m, rr_m);
      e = model_prod(longint'(fac1_a[g]), longint'(fac2_a[g]), int'(frac_a[g]));
      do_op(m, g, e, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
